// File: rtl/rolly_fifo_ptr_tracker.sv
// rolly_fifo_ptr_tracker
//   Pointer and status tracker for a "rolly" 1R1W FIFO of 2^lg_size_p entries.
//   Speculative writes advance wptr and become visible to the reader only when
//   committed into wcptr. Speculative reads advance rptr and release space to
//   the writer only when acknowledged into rcptr. Each pointer carries an
//   extra wrap bit so that full and empty can be told apart.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   reset_i      asynchronous active-high reset, clears all pointers
//   enq_i        write one entry at wptr this cycle
//   deq_i        consume one entry at rptr this cycle
//   r_incr_i     acknowledge one read: rcptr += 1
//   r_rewind_i   roll rptr back to rcptr
//   r_forward_i  acknowledge all reads: rcptr <= rptr
//   r_clear_i    drop all committed unread data: rptr, rcptr <= wcptr
//   w_incr_i     commit one write: wcptr += 1
//   w_rewind_i   drop uncommitted writes: wptr <= wcptr
//   w_forward_i  commit all writes: wcptr <= wptr
//   w_clear_i    drop all unread data: wptr, wcptr <= rptr
//   wptr_r_o     registered write pointer (memory write address)
//   rptr_r_o     registered read pointer
//   wcptr_r_o    registered write checkpoint
//   rcptr_r_o    registered read checkpoint
//   rptr_n_o     next read pointer (memory read address, covers RAM latency)
//   full_o       no space for enq
//   empty_o      no committed data to read

module rolly_fifo_ptr_tracker #(
  parameter int lg_size_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enq_i,
  input  logic                 deq_i,
  input  logic                 r_incr_i,
  input  logic                 r_rewind_i,
  input  logic                 r_forward_i,
  input  logic                 r_clear_i,
  input  logic                 w_incr_i,
  input  logic                 w_rewind_i,
  input  logic                 w_forward_i,
  input  logic                 w_clear_i,
  output logic [lg_size_p-1:0] wptr_r_o,
  output logic [lg_size_p-1:0] rptr_r_o,
  output logic [lg_size_p-1:0] wcptr_r_o,
  output logic [lg_size_p-1:0] rcptr_r_o,
  output logic [lg_size_p-1:0] rptr_n_o,
  output logic                 full_o,
  output logic                 empty_o
);

  // One extra MSB per pointer acts as the wrap bit.
  localparam int ptr_w = lg_size_p + 1;

  logic [ptr_w-1:0] wptr_reg,  wptr_next;
  logic [ptr_w-1:0] wcptr_reg, wcptr_next;
  logic [ptr_w-1:0] rptr_reg,  rptr_next;
  logic [ptr_w-1:0] rcptr_reg, rcptr_next;

  // Single-bit strobes zero-extended to pointer width for the adders.
  logic [ptr_w-1:0] enq_inc, deq_inc, r_inc, w_inc;

  assign enq_inc = {{lg_size_p{1'b0}}, enq_i};
  assign deq_inc = {{lg_size_p{1'b0}}, deq_i};
  assign r_inc   = {{lg_size_p{1'b0}}, r_incr_i};
  assign w_inc   = {{lg_size_p{1'b0}}, w_incr_i};

  // Next-state selection; earlier terms take priority over later ones.
  always_comb begin
    rptr_next = rptr_reg + deq_inc;
    if (r_clear_i)       rptr_next = wcptr_reg;
    else if (r_rewind_i) rptr_next = rcptr_reg + r_inc;

    rcptr_next = rcptr_reg + r_inc;
    if (r_clear_i)        rcptr_next = wcptr_reg;
    else if (r_forward_i) rcptr_next = rptr_reg;

    // A clear alongside a dequeue must skip the entry being consumed now.
    wptr_next = wptr_reg + enq_inc;
    if (w_clear_i)       wptr_next = rptr_reg + deq_inc;
    else if (w_rewind_i) wptr_next = wcptr_reg;

    // Forwarding alongside an enqueue commits the entry being written now.
    wcptr_next = wcptr_reg + w_inc;
    if (w_clear_i)        wcptr_next = rptr_reg + deq_inc;
    else if (w_forward_i) wcptr_next = wptr_reg + enq_inc;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_reg  <= '0;
      wcptr_reg <= '0;
      rptr_reg  <= '0;
      rcptr_reg <= '0;
    end else begin
      wptr_reg  <= wptr_next;
      wcptr_reg <= wcptr_next;
      rptr_reg  <= rptr_next;
      rcptr_reg <= rcptr_next;
    end
  end

  assign wptr_r_o  = wptr_reg[lg_size_p-1:0];
  assign wcptr_r_o = wcptr_reg[lg_size_p-1:0];
  assign rptr_r_o  = rptr_reg[lg_size_p-1:0];
  assign rcptr_r_o = rcptr_reg[lg_size_p-1:0];

  // Read address for the synchronous RAM; held at 0 while reset is asserted
  // so the memory sees the same address the pointer will hold afterwards.
  assign rptr_n_o = reset_i ? '0 : rptr_next[lg_size_p-1:0];

  // Readers only see committed data.
  assign empty_o = (rptr_reg == wcptr_reg);

  // Writers may not overwrite data that has not been acknowledged.
  assign full_o = (wptr_reg[lg_size_p-1:0] == rcptr_reg[lg_size_p-1:0])
               && (wptr_reg[lg_size_p] != rcptr_reg[lg_size_p]);

  // Conflicting read-checkpoint controls.
  a_no_rewind_forward : assert property (
    @(posedge clk_i) disable iff (reset_i) !(r_rewind_i && r_forward_i)
  );
  a_no_incr_forward : assert property (
    @(posedge clk_i) disable iff (reset_i) !(r_incr_i && r_forward_i)
  );

endmodule

// File: tb/tb_rolly_fifo_ptr_tracker.sv
module tb_rolly_fifo_ptr_tracker;

  localparam int LG = 2;

  localparam logic [9:0] OP_ENQ  = 10'd1;
  localparam logic [9:0] OP_DEQ  = 10'd2;
  localparam logic [9:0] OP_RINC = 10'd4;
  localparam logic [9:0] OP_RREW = 10'd8;
  localparam logic [9:0] OP_RFWD = 10'd16;
  localparam logic [9:0] OP_RCLR = 10'd32;
  localparam logic [9:0] OP_WINC = 10'd64;
  localparam logic [9:0] OP_WREW = 10'd128;
  localparam logic [9:0] OP_WFWD = 10'd256;
  localparam logic [9:0] OP_WCLR = 10'd512;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          enq_i = 1'b0, deq_i = 1'b0;
  logic          r_incr_i = 1'b0, r_rewind_i = 1'b0, r_forward_i = 1'b0, r_clear_i = 1'b0;
  logic          w_incr_i = 1'b0, w_rewind_i = 1'b0, w_forward_i = 1'b0, w_clear_i = 1'b0;
  logic [LG-1:0] wptr_r_o, rptr_r_o, wcptr_r_o, rcptr_r_o, rptr_n_o;
  logic          full_o, empty_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  rolly_fifo_ptr_tracker #(.lg_size_p(LG)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enq_i       (enq_i),
    .deq_i       (deq_i),
    .r_incr_i    (r_incr_i),
    .r_rewind_i  (r_rewind_i),
    .r_forward_i (r_forward_i),
    .r_clear_i   (r_clear_i),
    .w_incr_i    (w_incr_i),
    .w_rewind_i  (w_rewind_i),
    .w_forward_i (w_forward_i),
    .w_clear_i   (w_clear_i),
    .wptr_r_o    (wptr_r_o),
    .rptr_r_o    (rptr_r_o),
    .wcptr_r_o   (wcptr_r_o),
    .rcptr_r_o   (rcptr_r_o),
    .rptr_n_o    (rptr_n_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [9:0] ops);
    {w_clear_i, w_forward_i, w_rewind_i, w_incr_i, r_clear_i,
     r_forward_i, r_rewind_i, r_incr_i, deq_i, enq_i} = ops;
  endtask

  // One clock with the given controls; rptr_n_o seen before the edge must
  // become rptr_r_o after it.
  task automatic tick(input string tag, input logic [9:0] ops);
    logic [LG-1:0] rn;
    @(negedge clk_i);
    set_ops(ops);
    #1 rn = rptr_n_o;
    @(posedge clk_i);
    #1;
    set_ops(10'd0);
    check_eq({tag, ":rptr_n"}, 32'(rptr_r_o), 32'(rn));
    $display("%-10s ops=%b w=%0d wc=%0d r=%0d rc=%0d empty=%0b full=%0b",
             tag, ops, wptr_r_o, wcptr_r_o, rptr_r_o, rcptr_r_o, empty_o, full_o);
  endtask

  task automatic expect_state(input string tag, input int w, input int wc, input int r,
                              input int rc, input int e, input int f);
    check_eq({tag, ":wptr"},  32'(wptr_r_o),  32'(w));
    check_eq({tag, ":wcptr"}, 32'(wcptr_r_o), 32'(wc));
    check_eq({tag, ":rptr"},  32'(rptr_r_o),  32'(r));
    check_eq({tag, ":rcptr"}, 32'(rcptr_r_o), 32'(rc));
    check_eq({tag, ":empty"}, 32'(empty_o),   32'(e));
    check_eq({tag, ":full"},  32'(full_o),    32'(f));
  endtask

  // Asynchronous reset asserted between edges, with a dequeue request held
  // so that the rptr_n_o gating is observable.
  task automatic mid_reset(input string tag);
    @(negedge clk_i);
    #2 reset_i = 1'b1;
    deq_i = 1'b1;
    #1;
    expect_state(tag, 0, 0, 0, 0, 1, 0);
    check_eq({tag, ":rptr_n"}, 32'(rptr_n_o), 32'd0);
    $display("%-10s reset asserted mid-cycle", tag);
    @(negedge clk_i);
    deq_i = 1'b0;
    reset_i = 1'b0;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk_i);
    #1;
    expect_state("por", 0, 0, 0, 0, 1, 0);
    check_eq("por:rptr_n", 32'(rptr_n_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Basic commit
    for (int i = 0; i < 3; i++) tick("enq", OP_ENQ);
    expect_state("enq3", 3, 0, 0, 0, 1, 0);
    tick("wfwd", OP_WFWD);
    expect_state("wfwd", 3, 3, 0, 0, 0, 0);

    // Full and wrap
    tick("enqfwd", OP_ENQ | OP_WFWD);
    expect_state("full", 0, 0, 0, 0, 0, 1);
    tick("deq", OP_DEQ);
    expect_state("deq", 0, 0, 1, 0, 0, 1);
    tick("rfwd", OP_RFWD);
    expect_state("rfwd", 0, 0, 1, 1, 0, 0);
    tick("enqfwd", OP_ENQ | OP_WFWD);
    expect_state("full2", 1, 1, 1, 1, 0, 1);
    tick("deqinc", OP_DEQ | OP_RINC);
    expect_state("wrap_a", 1, 1, 2, 2, 0, 0);
    tick("deqinc", OP_DEQ | OP_RINC);
    expect_state("wrap_b", 1, 1, 3, 3, 0, 0);
    tick("deqinc", OP_DEQ | OP_RINC);
    expect_state("wrap_c", 1, 1, 0, 0, 0, 0);
    tick("deqinc", OP_DEQ | OP_RINC);
    expect_state("wrap_d", 1, 1, 1, 1, 1, 0);

    // Reset in the middle of a run
    mid_reset("rst1");
    expect_state("rst1post", 0, 0, 0, 0, 1, 0);

    // Read rollback
    for (int i = 0; i < 3; i++) tick("enq", OP_ENQ);
    tick("wfwd", OP_WFWD);
    tick("deq", OP_DEQ);
    tick("deq", OP_DEQ);
    expect_state("deq2", 3, 3, 2, 0, 0, 0);
    tick("rrew", OP_RREW);
    expect_state("rrew", 3, 3, 0, 0, 0, 0);
    tick("rrewinc", OP_RREW | OP_RINC);
    expect_state("rrewinc", 3, 3, 1, 1, 0, 0);

    // Write drop
    tick("enq", OP_ENQ);
    expect_state("wspec1", 0, 3, 1, 1, 0, 0);
    tick("enq", OP_ENQ);
    expect_state("wspec2", 1, 3, 1, 1, 0, 1);
    tick("wrew", OP_WREW);
    expect_state("wrew", 3, 3, 1, 1, 0, 0);
    tick("enqfwd", OP_ENQ | OP_WFWD);
    expect_state("enqfwd", 0, 0, 1, 1, 0, 0);

    // Write clear with dequeue from rptr=1, wcptr=3
    mid_reset("rst2");
    for (int i = 0; i < 3; i++) tick("enq", OP_ENQ);
    tick("wfwd", OP_WFWD);
    tick("deq", OP_DEQ);
    expect_state("preclr", 3, 3, 1, 0, 0, 0);
    tick("wclrdeq", OP_WCLR | OP_DEQ);
    expect_state("wclrdeq", 2, 2, 2, 0, 1, 0);

    // Read clear
    tick("enqfwd", OP_ENQ | OP_WFWD);
    tick("enqfwd", OP_ENQ | OP_WFWD);
    expect_state("prerclr", 0, 0, 2, 0, 0, 1);
    tick("rclr", OP_RCLR);
    expect_state("rclr", 0, 0, 0, 0, 1, 0);

    // Single-entry commit
    tick("enq", OP_ENQ);
    expect_state("enq1", 1, 0, 0, 0, 1, 0);
    tick("winc", OP_WINC);
    expect_state("winc", 1, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
